// File: rtl/reg_file_wb_if.sv
// Bus between the ALU datapath (master) and the write-back register file (slave).
//
// Handshake: there is no ready. WRITE and FLAG_EN are single-cycle enables
// sampled at every rising clock edge; the register file accepts a write on
// every cycle it is asserted and never stalls. Read ports are purely
// combinational and need no enable.
interface reg_file_wb_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   logic [DATA_W-1:0] IN;
   logic [ADDR_W-1:0] INADDRESS;
   logic              WRITE;
   logic [ADDR_W-1:0] OUT1ADDRESS;
   logic [ADDR_W-1:0] OUT2ADDRESS;
   logic [DATA_W-1:0] OUT1;
   logic [DATA_W-1:0] OUT2;
   logic              ZERO_IN;
   logic              FLAG_EN;
   logic              ZERO_FLAG;
   logic              PEND_VALID;

   modport master (
      output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, ZERO_IN, FLAG_EN,
      input  OUT1, OUT2, ZERO_FLAG, PEND_VALID
   );

   modport slave (
      input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, ZERO_IN, FLAG_EN,
      output OUT1, OUT2, ZERO_FLAG, PEND_VALID
   );
endinterface

// File: rtl/reg_file_wb.sv
// Write-back register file: 2 read ports, 1 write port. Writes sit in a
// one-entry pending stage for a cycle before committing to the array; both
// read ports forward from that stage so a read always sees the newest value.
// Also holds the registered ZERO flag used by branch logic.
module reg_file_wb #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int NREGS  = 2**ADDR_W
) (
   input logic          CLK,
   input logic          RESET,
   reg_file_wb_if.slave bus
);

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic              pend_valid_q, pend_valid_d;
   logic [ADDR_W-1:0] pend_addr_q,  pend_addr_d;
   logic [DATA_W-1:0] pend_data_q,  pend_data_d;
   logic              zero_flag_q,  zero_flag_d;

   // Next state: commit the pending entry, load a new one, update the flag.
   always_comb begin
      regs_d       = regs_q;
      pend_valid_d = bus.WRITE;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      zero_flag_d  = zero_flag_q;
      if (pend_valid_q) begin
         regs_d[pend_addr_q] = pend_data_q;
      end
      if (bus.WRITE) begin
         pend_addr_d = bus.INADDRESS;
         pend_data_d = bus.IN;
      end
      if (bus.FLAG_EN) begin
         zero_flag_d = bus.ZERO_IN;
      end
   end

   // State registers; reset clears everything and drops any pending write.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         zero_flag_q  <= 1'b0;
      end else begin
         regs_q       <= regs_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         zero_flag_q  <= zero_flag_d;
      end
   end

   // Read ports: forward from the pending stage when it holds the addressed register.
   always_comb begin
      bus.OUT1 = regs_q[bus.OUT1ADDRESS];
      bus.OUT2 = regs_q[bus.OUT2ADDRESS];
      if (pend_valid_q && (pend_addr_q == bus.OUT1ADDRESS)) begin
         bus.OUT1 = pend_data_q;
      end
      if (pend_valid_q && (pend_addr_q == bus.OUT2ADDRESS)) begin
         bus.OUT2 = pend_data_q;
      end
   end

   // Status outputs straight from their registers.
   always_comb begin
      bus.ZERO_FLAG  = zero_flag_q;
      bus.PEND_VALID = pend_valid_q;
   end

endmodule
